// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit
// seven-segment display. One shared hex decoder is time-shared across the
// digits; each digit slot starts with a dark window to avoid ghosting, and
// new values are staged so that a frame never mixes old and new digits.
//
// Handshake note: there is no valid/ready pair here. 'load' is a one-cycle
// strobe that is always accepted: it either stages the bus into pend_*
// (scanning) or, on a frame-boundary cycle or while disabled, writes the
// bus straight into the displayed shadow registers.
module seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  output logic [3:0]        dec_din,
  input  logic [7:0]        dec_dout,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   dig_sel,
  output logic              frame_done
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
  localparam logic [TW-1:0] BLANK_TICK = TW'(BLANK);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Scan position; 'state' is a pure function of en and tick.
  state_t          state;
  logic [TW-1:0]   tick, tick_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic            boundary;

  logic [4*NDIG-1:0] shadow_val, pend_val;
  logic [NDIG-1:0]   shadow_dp, pend_dp;
  logic              pend_v;
  logic              dp_cur;

  // Scan position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
      idx  <= '0;
    end else begin
      tick <= tick_nxt;
      idx  <= idx_nxt;
    end
  end

  // Slot phase decode and next scan position; the frame boundary is the last
  // tick of the last digit.
  always_comb begin
    state    = ST_OFF;
    tick_nxt = tick;
    idx_nxt  = idx;
    boundary = 1'b0;
    if (en) begin
      state = (tick < BLANK_TICK) ? ST_BLANK : ST_SHOW;
    end
    case (state)
      ST_OFF: begin
        tick_nxt = '0;
        idx_nxt  = '0;
      end
      default: begin
        if (tick == TICK_LAST) begin
          tick_nxt = '0;
          idx_nxt  = (idx == IDX_LAST) ? '0 : idx + IW'(1);
          boundary = (idx == IDX_LAST);
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
    endcase
  end

  // Select the current digit's nibble and decimal point from the shadow copy.
  always_comb begin
    dec_din = 4'h0;
    dp_cur  = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        dec_din = shadow_val[4*i +: 4];
        dp_cur  = shadow_dp[i];
      end
    end
  end

  // Registered pin drive: dark outside SHOW; the decoder's own dp bit is
  // replaced by the per-digit decimal point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (state == ST_SHOW) begin
        seg     <= {dec_dout[7:1], dp_cur};
        dig_sel <= NDIG'(1) << idx;
      end else begin
        seg     <= '0;
        dig_sel <= '0;
      end
    end
  end

  // Load staging and tear-free transfer into the displayed copy. While
  // disabled nothing is on the pins, so a load goes straight to the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_v     <= 1'b0;
    end else if (!en) begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pend_v     <= 1'b0;
      end
    end else if (boundary) begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pend_v     <= 1'b0;
      end else if (pend_v) begin
        shadow_val <= pend_val;
        shadow_dp  <= pend_dp;
        pend_v     <= 1'b0;
      end
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend_v   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random en/load traffic,
// checked cycle by cycle against a time-count based display model.
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int P     = 8;
  localparam int BL    = 2;
  localparam int FRAME = NDIG * P;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              en = 1'b0;
  logic              load = 1'b0;
  logic [4*NDIG-1:0] value = '0;
  logic [NDIG-1:0]   dp_in = '0;
  logic [3:0]        dec_din;
  logic [7:0]        dec_dout;
  logic [7:0]        seg;
  logic [NDIG-1:0]   dig_sel;
  logic              frame_done;

  seg_scan_ctrl #(.NDIG(NDIG), .PRESCALE(P), .BLANK(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .dec_din(dec_din), .dec_dout(dec_dout), .seg(seg),
    .dig_sel(dig_sel), .frame_done(frame_done)
  );

  // Reference hex decoder {a..g}
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1111110;  4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;  4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;  4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;  4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;  4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;  4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;  4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;  default: seg7 = 7'b1000111;
    endcase
  endfunction

  // External decoder always reports dp=1 so the DUT must substitute its own.
  assign dec_dout = {seg7(dec_din), 1'b1};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_cnt counts enabled edges since the last disable/reset; the scan
  // position follows from it by division.
  int                m_cnt = 0;
  logic [4*NDIG-1:0] m_sval = '0, m_pval = '0;
  logic [NDIG-1:0]   m_sdp = '0, m_pdp = '0;
  logic              m_pv = 1'b0;
  logic [7:0]        e_seg = '0;
  logic [NDIG-1:0]   e_dig = '0;
  logic              e_fd = 1'b0;
  logic [3:0]        e_din = '0;

  function automatic logic [3:0] nib(input logic [4*NDIG-1:0] v, input int d);
    nib = 4'((v >> (4 * d)) & 16'hF);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_sval = '0; m_pval = '0; m_sdp = '0; m_pdp = '0; m_pv = 1'b0;
    e_seg = '0; e_dig = '0; e_fd = 1'b0; e_din = '0;
  endtask

  task automatic model_edge();
    int pos, d;
    bit bnd;
    if (en) begin
      pos = m_cnt % P;
      d   = (m_cnt / P) % NDIG;
      bnd = (m_cnt % FRAME) == FRAME - 1;
      if (pos < BL) begin
        e_dig = '0; e_seg = '0;
      end else begin
        e_dig = NDIG'(1 << d);
        e_seg = {seg7(nib(m_sval, d)), m_sdp[d]};
      end
      e_fd = bnd;
      if (bnd && load) begin
        m_sval = value; m_sdp = dp_in; m_pv = 1'b0;
      end else if (bnd && m_pv) begin
        m_sval = m_pval; m_sdp = m_pdp; m_pv = 1'b0;
      end else if (!bnd && load) begin
        m_pval = value; m_pdp = dp_in; m_pv = 1'b1;
      end
      m_cnt++;
    end else begin
      e_dig = '0; e_seg = '0; e_fd = 1'b0;
      m_cnt = 0;
      if (load) begin
        m_sval = value; m_sdp = dp_in; m_pv = 1'b0;
      end
    end
    e_din = nib(m_sval, (m_cnt / P) % NDIG);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model and DUT advance together, outputs compared 1 ns later,
  // load strobe dropped afterwards.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dig_sel", 32'(dig_sel), 32'(e_dig));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("dec_din", 32'(dec_din), 32'(e_din));
    load = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
  endtask

  // Advance until the next enabled edge lands on frame phase ph.
  task automatic run_to_phase(input int ph);
    int guard = 0;
    while ((m_cnt % FRAME) != ph && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    chk("phase_reached", 32'((m_cnt % FRAME) == ph), 32'd1);
  endtask

  task automatic wait_frame_done();
    int guard = 0;
    while (frame_done !== 1'b1 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  // Asynchronous reset between edges (called at posedge+1).
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_seg", 32'(seg), 32'd0);
    chk("arst_dig_sel", 32'(dig_sel), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    chk("arst_dec_din", 32'(dec_din), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_dig_sel", 32'(dig_sel), 32'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int seen_1111;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_dig_sel", 32'(dig_sel), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_dec_din", 32'(dec_din), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;

    // First frame after release: two dark edges, then digit 0 showing "0"
    steps(2);
    chk("start_dark", 32'(dig_sel), 32'd0);
    step();
    chk("start_dig0", 32'(dig_sel), 32'b0001);
    chk("start_seg0", 32'(seg), 32'b11111100);
    steps(2 * FRAME);

    // Mid-frame load of 4321: old digits until boundary, then new frame
    run_to_phase(10);
    do_load(16'h4321, 4'b0100);
    wait_frame_done();
    steps(3);
    chk("f4321_dig0", 32'(dig_sel), 32'b0001);
    chk("f4321_seg0", 32'(seg), 32'b01100000);
    steps(8);
    chk("f4321_dig1", 32'(dig_sel), 32'b0010);
    chk("f4321_seg1", 32'(seg), 32'b11011010);
    steps(8);
    chk("f4321_dig2", 32'(dig_sel), 32'b0100);
    chk("f4321_seg2", 32'(seg), 32'b11110011);
    steps(8);
    chk("f4321_dig3", 32'(dig_sel), 32'b1000);
    chk("f4321_seg3", 32'(seg), 32'b01100110);

    // Two loads in one frame: the later one wins, the first is never shown
    run_to_phase(4);
    do_load(16'h1111, 4'b0000);
    steps(5);
    do_load(16'h2222, 4'b0000);
    seen_1111 = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (dig_sel != 0 && seg[7:1] == seg7(4'h1)) seen_1111++;
    end
    chk("no_1111_shown", 32'(seen_1111), 32'd0);

    // Load exactly on the boundary cycle
    run_to_phase(FRAME - 1);
    do_load(16'hA5C3, 4'b1010);
    chk("bnd_frame_done", 32'(frame_done), 32'd1);
    steps(3);
    chk("bnd_seg0", 32'(seg), {24'd0, seg7(4'h3), 1'b0});
    steps(2 * FRAME);

    // Disable at tick 5 of digit 2, load while disabled, re-enable
    run_to_phase(2 * P + 5);
    en = 1'b0;
    step();
    chk("off_dig_sel", 32'(dig_sel), 32'd0);
    chk("off_seg", 32'(seg), 32'd0);
    do_load(16'h9876, 4'b0001);
    steps(3);
    en = 1'b1;
    steps(2);
    chk("reen_dark", 32'(dig_sel), 32'd0);
    step();
    chk("reen_dig0", 32'(dig_sel), 32'b0001);
    chk("reen_seg0", 32'(seg), {24'd0, seg7(4'h6), 1'b1});

    // Async reset in the middle of a SHOW window
    run_to_phase(P + 4);
    step();
    async_reset();
    steps(3);
    chk("post_rst_dig0", 32'(dig_sel), 32'b0001);
    chk("post_rst_seg0", 32'(seg), 32'b11111100);
    steps(FRAME);

    // Random en / load traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        value = 16'($urandom);
        dp_in = 4'($urandom);
        load = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display. It owns one shared combinational hex-to-segment decoder and steps through the digits in turn. For each digit it presents that digit's nibble to the decoder, registers the returned pattern with a per-digit decimal point, and drives one digit-select line. Anti-ghosting blanking, tear-free value loading and an enable gate are built in. It sits between the numeric datapath, which supplies values, and the display pins.

## Interface
- NDIG, 4: number of digits, legal range 1..8.
- PRESCALE, 1000: clock cycles per digit slot; must be greater than BLANK.
- BLANK, 16: dark cycles at the start of each slot; 0 is legal.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; 0 turns the display dark.
- load  in  1  one-cycle strobe that captures value and dp_in.
- value  in  4*NDIG  digit i is value[4i+3:4i].
- dp_in  in  NDIG  decimal point for digit i.
- dec_din  out  4  nibble sent to the shared decoder.
- dec_dout  in  8  decoder result {a,b,c,d,e,f,g,dp}, active-high, combinational from dec_din.
- seg  out  8  {a..g,dp}, active-high, registered.
- dig_sel  out  NDIG  one-hot active-high digit enable, registered.
- frame_done  out  1  one-cycle pulse after each complete frame, registered.

## Operation
- Internal registers:
  - tick: 0..PRESCALE-1.
  - idx: 0..NDIG-1.
  - shadow_val, shadow_dp: the values currently displayed.
  - pend_val, pend_dp, pend_v: a staged load waiting for a frame boundary.
- dec_din = shadow_val nibble at idx. It is combinational from registers and held for the whole slot.
- States:
  - OFF when en=0.
  - BLANK when en=1 and tick<BLANK.
  - SHOW when en=1 and tick>=BLANK.
- Register update on each edge:
  - OFF: tick and idx go to 0; seg and dig_sel go to 0.
  - BLANK: seg and dig_sel go to 0.
  - SHOW: dig_sel = 1<<idx; seg = {dec_dout[7:1], shadow_dp[idx]}. The decoder's dp bit is ignored.
- Counter advance, only when en=1:
  - tick increments each cycle.
  - When tick = PRESCALE-1, tick wraps to 0 and idx increments, wrapping from NDIG-1 to 0.
- Frame boundary: the cycle with en=1, tick=PRESCALE-1 and idx=NDIG-1. On that edge, frame_done goes to 1 for one cycle.
- Load staging:
  - load=1 captures value and dp_in into pend_* and sets pend_v.
  - A later load before the boundary overwrites pend_*; the last one wins.
- Shadow transfer:
  - At a frame boundary with pend_v=1, pend_* moves to shadow_* and pend_v clears.
  - If load=1 on the boundary cycle itself, the bus values go straight to shadow_* and pend_v clears.
- With en=0, shadow_* takes a load on the edge after the strobe, since there is no tearing risk.
- Reset: tick, idx, shadow_*, pend_* and pend_v go to 0; seg, dig_sel and frame_done go to 0. Reset is effective immediately, even mid-slot.
- Guarantee: dig_sel never has more than one bit set. When dig_sel=0, seg is 0.

## Timing
- Outputs trail the state of tick and idx by one cycle.
- Per slot:
  - BLANK cycles with dig_sel=0, then PRESCALE-BLANK cycles with dig_sel one-hot.
  - The frame period is NDIG*PRESCALE cycles.
- en rising: on the first edge with en=1, tick=0 and idx=0. Digit 0 lights on edge BLANK+1 (counting that first edge as edge 1).
- en falling mid-slot: outputs go dark on the next edge and tick and idx reset. The next en=1 restarts at digit 0.
- A new value appears no earlier than the first slot of the next frame, so no frame ever mixes old and new digits.
- A load strobe while pend_v=1 replaces the staged value without delay.
- BLANK=0: no dark cycles; dig_sel moves directly from digit i to digit i+1.

## Test plan
Use NDIG=4, PRESCALE=8, BLANK=2, and a reference decoder for 0-F.
- Reset release with en=1 and shadow=0: dig_sel=0 on edges 1-2, dig_sel=4'b0001 with seg=8'b11111100 on edges 3-8, then 2 dark cycles, then 4'b0010. frame_done pulses once every 32 cycles.
- load with value=16'h4321 and dp_in=4'b0100 mid-frame:
  - Required: old digits persist until the frame boundary.
  - Required next frame: digit 0 shows seg 01100000, digit 1 shows 11011010, digit 2 shows 11110011 (dp set), digit 3 shows 01100110.
- Loads with values 16'h1111 and then 16'h2222 within one frame: only 2222 is ever displayed.
- load on the exact boundary cycle: the new value shows on digit 0 of the next frame, and pend_v=0 afterwards.
- en dropped at tick 5 of digit 2: the next edge gives dig_sel=0 and seg=0. After en is raised again, digit 0 lights after 2 dark cycles.
- rst_n asserted mid-SHOW (asynchronously, between edges): all outputs go to 0 immediately. After release, the display shows 0000, proving the shadow was cleared.
